conv_mac_engine: RTL and testbench

Parametrised successor to the fixed 4-lane mac/acc/neu_rdy/out_mux datapath in the conv accelerator top level. It accepts packed ifm/weight vectors from the input and weight buffers as a valid/ready stream and multiplies LANES pairs per beat. It accumulates across beats until a neuron boundary, then applies shift, saturation and optional ReLU. It packs OUT_CH neuron results into one output-buffer word with its write address, and applies backpressure when the output side stalls.

---
 rtl/conv_pkg.sv | 48 ++++
 rtl/mac_lane_tree.sv | 74 +++++++
 rtl/conv_mac_engine.sv | 155 +++++++++++++++
 tb/tb_conv_mac_engine.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types, default sizes and element helpers for the conv MAC engine.
package conv_pkg;

    localparam int LANES_DEF   = 4;
    localparam int DATA_W_DEF  = 16;
    localparam int ACC_W_DEF   = 40;
    localparam int OUT_CH_DEF  = 4;
    localparam int ADDR_W_DEF  = 16;
    localparam int SHIFT_W_DEF = 6;
    localparam int SAT_W       = 64;

    typedef struct packed {
        logic valid;
        logic last;
    } beat_ctl_t;

    function automatic int acc_w_min(input int lanes, input int data_w,
                                     input int headroom);
        return 2 * data_w + $clog2(lanes) + headroom;
    endfunction

    // Element 0 sits in the MSBs of a packed vector.
    function automatic int elem_lsb(input int idx, input int n, input int w);
        return (n - 1 - idx) * w;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_relu(
        input logic signed [SAT_W-1:0] x,
        input int                      data_w,
        input logic                    relu
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] r;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi)
            r = hi;
        else if (x < lo)
            r = lo;
        else
            r = x;
        if (relu && r[SAT_W-1])
            r = '0;
        return r;
    endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// Registered lane multipliers followed by a registered sign-extended sum.
module mac_lane_tree
    import conv_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [LANES*DATA_W-1:0] in_ifm,
    input  logic [LANES*DATA_W-1:0] in_w,
    output logic                    sum_valid,
    output logic                    sum_last,
    output logic signed [ACC_W-1:0] sum,
    output logic                    pipe_busy
);

    localparam int PROD_W = 2 * DATA_W;

    beat_ctl_t                     s1_q, s1_d;
    beat_ctl_t                     s2_q, s2_d;
    logic [LANES-1:0][PROD_W-1:0]  prod_q, prod_d;
    logic signed [ACC_W-1:0]       sum_q, sum_d;
    logic signed [ACC_W-1:0]       tree;

    always_comb begin
        s1_d   = s1_q;
        s2_d   = s2_q;
        prod_d = prod_q;
        sum_d  = sum_q;
        tree   = '0;
        for (int i = 0; i < LANES; i++)
            tree = tree + ACC_W'($signed(prod_q[i]));
        if (clr) begin
            s1_d = '0;
            s2_d = '0;
        end else if (en) begin
            s1_d.valid = in_valid;
            s1_d.last  = in_valid & in_last;
            for (int i = 0; i < LANES; i++) begin
                prod_d[i] =
                    PROD_W'($signed(in_ifm[elem_lsb(i, LANES, DATA_W) +: DATA_W]))
                  * PROD_W'($signed(in_w[elem_lsb(i, LANES, DATA_W) +: DATA_W]));
            end
            s2_d  = s1_q;
            sum_d = tree;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prod_q <= '0;
            sum_q  <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prod_q <= prod_d;
            sum_q  <= sum_d;
        end
    end

    assign sum_valid = s2_q.valid;
    assign sum_last  = s2_q.last;
    assign sum       = sum_q;
    assign pipe_busy = s1_q.valid | s2_q.valid;

endmodule

// File: rtl/conv_mac_engine.sv
// Streaming MAC engine: lane products, neuron accumulation, requantisation
// and packing of OUT_CH results into addressed output words.
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int OUT_CH  = OUT_CH_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic                     cfg_relu,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  in_ifm,
    input  logic [LANES*DATA_W-1:0]  in_w,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_CH*DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     busy
);

    localparam int KW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int OW = OUT_CH * DATA_W;

    // One beat's full product sum must fit; extra headroom is the integrator's call.
    if (ACC_W < acc_w_min(LANES, DATA_W, 0) || ACC_W > SAT_W) begin : g_bad_acc_w
        $error("conv_mac_engine: ACC_W out of range");
    end

    logic                    stall;
    logic                    en;
    logic                    accept;
    logic                    s2_valid;
    logic                    s2_last;
    logic signed [ACC_W-1:0] s2_sum;
    logic                    pipe_busy;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    acc_open_q, acc_open_d;
    logic [KW-1:0]           k_q, k_d;
    logic [OW-1:0]           pack_q, pack_d;
    logic                    out_valid_q, out_valid_d;
    logic [OW-1:0]           out_data_q, out_data_d;
    logic [ADDR_W-1:0]       out_addr_q, out_addr_d;

    logic signed [ACC_W-1:0] acc_new;
    logic signed [ACC_W-1:0] shifted;
    logic [DATA_W-1:0]       res;
    logic [OW-1:0]           pack_w;
    logic                    last_slot;

    assign stall    = out_valid_q & ~out_ready;
    assign en       = ~stall;
    assign in_ready = rst_n & ~stall;
    assign accept   = in_valid & in_ready & ~start;

    mac_lane_tree #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (start),
        .in_valid  (accept),
        .in_last   (in_last),
        .in_ifm    (in_ifm),
        .in_w      (in_w),
        .sum_valid (s2_valid),
        .sum_last  (s2_last),
        .sum       (s2_sum),
        .pipe_busy (pipe_busy)
    );

    always_comb begin
        acc_new   = (acc_open_q ? acc_q : '0) + s2_sum;
        shifted   = $signed(acc_new) >>> cfg_shift;
        res       = DATA_W'(sat_relu(SAT_W'(shifted), DATA_W, cfg_relu));
        pack_w    = pack_q;
        pack_w[elem_lsb(int'(k_q), OUT_CH, DATA_W) +: DATA_W] = res;
        last_slot = (k_q == KW'(OUT_CH - 1));
    end

    always_comb begin
        acc_d       = acc_q;
        acc_open_d  = acc_open_q;
        k_d         = k_q;
        pack_d      = pack_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        if (start) begin
            acc_d       = '0;
            acc_open_d  = 1'b0;
            k_d         = '0;
            pack_d      = '0;
            out_valid_d = 1'b0;
            out_addr_d  = '0;
        end else if (!stall) begin
            if (out_valid_q) begin
                out_valid_d = 1'b0;
                out_addr_d  = out_addr_q + ADDR_W'(1);
            end
            if (s2_valid) begin
                acc_d      = acc_new;
                acc_open_d = ~s2_last;
                if (s2_last) begin
                    pack_d = pack_w;
                    if (last_slot) begin
                        k_d         = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = pack_w;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            acc_open_q  <= 1'b0;
            k_q         <= '0;
            pack_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            acc_open_q  <= acc_open_d;
            k_q         <= k_d;
            pack_q      <= pack_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = pipe_busy | (k_q != '0) | out_valid_q | acc_open_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Scoreboard bench for conv_mac_engine with directed neuron vectors.
module tb_conv_mac_engine;

    localparam int LANES   = 4;
    localparam int DATA_W  = 16;
    localparam int ACC_W   = 40;
    localparam int OUT_CH  = 4;
    localparam int ADDR_W  = 2;
    localparam int SHIFT_W = 6;
    localparam int VW      = LANES * DATA_W;
    localparam int OW      = OUT_CH * DATA_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [SHIFT_W-1:0] cfg_shift = '0;
    logic               cfg_relu = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic [VW-1:0]      in_ifm = '0;
    logic [VW-1:0]      in_w = '0;
    logic               out_ready = 1'b1;
    logic               in_ready;
    logic               out_valid;
    logic               busy;
    logic [OW-1:0]      out_data;
    logic [ADDR_W-1:0]  out_addr;

    typedef struct packed {
        logic [OW-1:0]     data;
        logic [ADDR_W-1:0] addr;
    } word_t;

    word_t             exp_q[$];
    word_t             mon_e;
    logic [ADDR_W-1:0] exp_addr = '0;
    int                n_checks = 0;
    int                n_pass = 0;
    logic [OW-1:0]     bp_words [3] = '{64'h0001_0002_0003_0004,
                                        64'h0005_0006_0007_0008,
                                        64'h0009_000A_000B_000C};

    conv_mac_engine #(
        .LANES   (LANES),
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .OUT_CH  (OUT_CH),
        .ADDR_W  (ADDR_W),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ifm    (in_ifm),
        .in_w      (in_w),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        n_checks++;
        if (act === want)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", name, act, want);
    endtask

    function automatic logic [VW-1:0] vec4(input int a, input int b,
                                           input int c, input int d);
        return {16'(a), 16'(b), 16'(c), 16'(d)};
    endfunction

    task automatic push(input logic [OW-1:0] data);
        exp_q.push_back('{data: data, addr: exp_addr});
        exp_addr = exp_addr + 1'b1;
    endtask

    task automatic send(input logic [VW-1:0] ifm, input logic [VW-1:0] w,
                        input logic last);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_ifm   = ifm;
        in_w     = w;
        in_last  = last;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stayed 0, want 1");
        end
    endtask

    task automatic neuron(input logic [VW-1:0] ifm, input logic [VW-1:0] w,
                          input int beats);
        for (int b = 0; b < beats; b++)
            send(ifm, w, b == beats - 1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge clk);
            idle = !busy && exp_q.size() == 0;
        end
        chk("idle", 64'(idle), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic mix_word();
        neuron(vec4(-100, 0, 0, 0), vec4(100, 0, 0, 0), 1);
        neuron(vec4(-100, -100, -100, -100), vec4(100, 100, 100, 100), 1);
        neuron(vec4(1, 2, 3, 4), vec4(5, 6, 7, 8), 1);
        neuron(vec4(1, 1, 1, 1), vec4(2, 2, 2, 2), 3);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got %h addr %0d, want none",
                         out_data, out_addr);
            end else if (out_ready) begin
                mon_e = exp_q.pop_front();
                chk("word_data", 64'(out_data), 64'(mon_e.data));
                chk("word_addr", 64'(out_addr), 64'(mon_e.addr));
            end else begin
                chk("hold_data", 64'(out_data), 64'(exp_q[0].data));
                chk("hold_addr", 64'(out_addr), 64'(exp_q[0].addr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_addr", 64'(out_addr), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        repeat (4) neuron(vec4(1, 2, 3, 4), vec4(5, 6, 7, 8), 1);
        push(64'h0046_0046_0046_0046);
        wait_idle();

        repeat (4) neuron(vec4(1, 1, 1, 1), vec4(2, 2, 2, 2), 3);
        push(64'h0018_0018_0018_0018);
        wait_idle();

        cfg_shift = 6'd2;
        repeat (4) neuron(vec4(1, 1, 1, 1), vec4(2, 2, 2, 2), 3);
        push(64'h0006_0006_0006_0006);
        wait_idle();
        cfg_shift = 6'd0;

        repeat (4)
            neuron(vec4(30000, 30000, 30000, 30000),
                   vec4(30000, 30000, 30000, 30000), 1);
        push(64'h7FFF_7FFF_7FFF_7FFF);
        wait_idle();

        mix_word();
        push(64'hD8F0_8000_0046_0018);
        wait_idle();

        cfg_relu = 1'b1;
        mix_word();
        push(64'h0000_0000_0046_0018);
        wait_idle();
        cfg_relu = 1'b0;

        cfg_shift = 6'd4;
        mix_word();
        push(64'hFD8F_F63C_0004_0001);
        wait_idle();
        cfg_shift = 6'd0;

        out_ready = 1'b0;
        fork
            begin
                for (int w = 0; w < 3; w++) begin
                    for (int s = 0; s < 4; s++)
                        neuron(vec4(4 * w + s + 1, 0, 0, 0),
                               vec4(1, 0, 0, 0), 1);
                    push(bp_words[w]);
                end
            end
            begin
                bit seen = 1'b0;
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                chk("bp_valid_seen", 64'(seen), 64'(1));
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    chk("bp_in_ready", 64'(in_ready), 64'(0));
                end
                out_ready = 1'b1;
            end
        join
        wait_idle();

        send(vec4(1, 1, 1, 1), vec4(2, 2, 2, 2), 1'b0);
        send(vec4(1, 1, 1, 1), vec4(2, 2, 2, 2), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_out_data", 64'(out_data), 64'(0));
        chk("mid_rst_out_addr", 64'(out_addr), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_addr = '0;
        @(posedge clk);
        #1;
        repeat (4) neuron(vec4(1, 1, 1, 1), vec4(2, 2, 2, 2), 3);
        push(64'h0018_0018_0018_0018);
        wait_idle();

        neuron(vec4(1, 1, 1, 1), vec4(2, 2, 2, 2), 1);
        send(vec4(1, 1, 1, 1), vec4(2, 2, 2, 2), 1'b0);
        send(vec4(1, 1, 1, 1), vec4(2, 2, 2, 2), 1'b0);
        start    = 1'b1;
        in_valid = 1'b1;
        in_ifm   = vec4(7, 7, 7, 7);
        in_w     = vec4(7, 7, 7, 7);
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_addr = '0;
        chk("start_busy", 64'(busy), 64'(0));
        chk("start_out_addr", 64'(out_addr), 64'(0));
        chk("start_out_valid", 64'(out_valid), 64'(0));
        repeat (4) neuron(vec4(1, 2, 3, 4), vec4(5, 6, 7, 8), 1);
        push(64'h0046_0046_0046_0046);
        wait_idle();

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
